line_regression: RTL and testbench
==================================

LINE_REGRESSION -- requirements
Module: line_regression

Interface
REQ-001 Parameter H_WIDTH, default 11: pixel x coordinate width.
REQ-002 Parameter V_WIDTH, default 10: pixel y coordinate width.
REQ-003 Parameter FRAC_BITS, default 8: fractional bits of m_out/b_out.
REQ-004 clk_in  input  1  system clock; the block uses one clock, all logic on its rising edge.
REQ-005 rst_in  input  1  reset; synchronous, active-high.
REQ-006 x_in  input  H_WIDTH  x of current masked pixel.
REQ-007 y_in  input  V_WIDTH  y of current masked pixel.
REQ-008 valid_in  input  1  x_in/y_in is a tracked pixel; accumulate it.
REQ-009 tabulate_in  input  1  end of frame; close accumulation and start the fit.
REQ-010 m_out  output  25  signed slope dy/dx, 1 sign . 16 int . 8 frac.
REQ-011 b_out  output  25  signed intercept, same format.
REQ-012 x_com_out  output  H_WIDTH  integer mean x.
REQ-013 y_com_out  output  V_WIDTH  integer mean y.
REQ-014 valid_out  output  1  one-cycle pulse; all outputs are new and held until the next pulse.
REQ-015 busy_out  output  1  fit in progress.

Function
REQ-016 On each valid_in, add 1 to N, and add x, y, x*x and x*y to Sx, Sy, Sxx and Sxy; widths are sized for no overflow at 1024x768.
REQ-017 On tabulate_in while idle, snapshot N/Sx/Sy/Sxx/Sxy, clear the accumulators, and enter PREP; a pixel in the same cycle belongs to the closing frame.
REQ-018 Accumulation continues during busy; those pixels belong to the next frame.
REQ-019 tabulate_in while busy is ignored; the accumulators are not cleared.
REQ-020 FSM states and order: IDLE, PREP (2 cycles), DIV_X, DIV_Y, DIV_M, DIV_B, DONE (1 cycle), then IDLE.
REQ-021 PREP computes num = N*Sxy - Sx*Sy and den = N*Sxx - Sx*Sx, both 72-bit signed.
REQ-022 Divisions:
  - DIV_X: x_com = Sx/N.
  - DIV_Y: y_com = Sy/N.
  - DIV_M: m = (num<<FRAC_BITS)/den.
  - DIV_B: b = ((Sy<<FRAC_BITS) - m*Sx)/N.
REQ-023 All divisions use magnitudes with the sign applied afterwards, truncating toward zero.
REQ-024 Each division takes exactly 66 cycles.
REQ-025 m is saturated to ±(2^24-1) before DIV_B and on output.
REQ-026 valid_out pulses exactly 268 cycles after the cycle tabulate_in is accepted, independent of data.
REQ-027 If N==0, all outputs are 0 at the valid_out pulse, with the same latency.
REQ-028 If den==0 and N>0 (vertical line), m_out is 25'h0FFFFFF, b_out is 0, and the coms are computed normally.
REQ-029 busy_out is high from the cycle after acceptance through the DONE cycle.

Reset
REQ-030 rst_in clears the accumulators and the snapshot, forces IDLE, drives all outputs to 0, and aborts any fit with no valid_out.
REQ-031 Reset mid-fit gives a clean next frame; the aborted result is never emitted.

Configuration
REQ-032 With LINE_REGRESSION_COUNT_EN defined, add output count_out (20 bits), which carries the snapshot N and updates at the valid_out pulse; reset value is 0.
REQ-033 Without LINE_REGRESSION_COUNT_EN, count_out is absent and behaviour is otherwise identical.

Structure
REQ-034 Package line_regression_pkg holds:
  - the fixed-point widths (25 total, 8 frac);
  - the saturation constants;
  - the FSM state enum;
  - the division latency (66).
REQ-035 There is one sub-module, seq_divider: a 64-bit restoring unsigned divider with start/done, one quotient bit per cycle, instantiated once and time-shared by the four divisions.

Verification
REQ-036 Pixels (x,x) for x=0..99, then tabulate -> m_out=0x000100, b_out=0, x_com=49, y_com=49, valid_out at +268.
REQ-037 Pixels (x,50) for x=100..199 -> m_out=0, b_out=0x003200, x_com=149, y_com=50.
REQ-038 Pixels (300,y) for y=0..99 -> m_out=0x0FFFFFF, b_out=0, x_com=300, y_com=49.
REQ-039 tabulate with no pixels -> all outputs 0, valid_out at +268.
REQ-040 rst_in 100 cycles into a fit -> no valid_out and outputs 0; the following y=x frame passes as in REQ-036.
REQ-041 Second tabulate at +50 plus the y=50 line fed while busy -> first result unchanged; a later tabulate yields the REQ-037 result.

Source files
------------

// File: rtl/line_regression_pkg.sv
// line_regression_pkg: fixed-point widths, saturation limits, FSM states and divider latency
// shared by line_regression and its divider.
package line_regression_pkg;
  localparam int FP_W = 25;
  localparam int FP_FRAC = 8;
  localparam logic [FP_W-1:0] M_MAX = 25'h0FFFFFF;
  localparam logic [FP_W-1:0] M_MIN = 25'h1000001;
  localparam int DIV_LAT = 66;
  localparam int DIV_W = 64;
  localparam int N_W = 20;
  localparam int S_W = 32;
  localparam int SS_W = 48;
  localparam int PROD_W = 72;
  typedef enum logic [2:0] {IDLE, PREP, DIV_X, DIV_Y, DIV_M, DIV_B, DONE} state_t;
  function automatic logic [FP_W-1:0] sat_fp(input logic [DIV_W-1:0] mag, input logic neg);
    return mag > DIV_W'(M_MAX) ? (neg ? M_MIN : M_MAX) : neg ? -mag[FP_W-1:0] : mag[FP_W-1:0];
  endfunction
endpackage

// File: rtl/line_regression_if.sv
// line_regression_if: pixel stream in, fit results out; master drives pixels, slave is the fitter.
interface line_regression_if import line_regression_pkg::*; #(
  parameter int H_WIDTH = 11,
  parameter int V_WIDTH = 10
) ();
  logic [H_WIDTH-1:0] x_in;
  logic [V_WIDTH-1:0] y_in;
  logic valid_in;
  logic tabulate_in;
  logic [FP_W-1:0] m_out;
  logic [FP_W-1:0] b_out;
  logic [H_WIDTH-1:0] x_com_out;
  logic [V_WIDTH-1:0] y_com_out;
  logic valid_out;
  logic busy_out;
  modport master (output x_in, y_in, valid_in, tabulate_in,
                  input m_out, b_out, x_com_out, y_com_out, valid_out, busy_out);
  modport slave (input x_in, y_in, valid_in, tabulate_in,
                 output m_out, b_out, x_com_out, y_com_out, valid_out, busy_out);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: 64-bit restoring unsigned divider, one quotient bit per cycle; done pulses 65 cycles after start.
module seq_divider import line_regression_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic done
);
  logic [DIV_W-1:0] rem, dvs;
  logic [6:0] cnt;
  logic [DIV_W:0] shifted, diff;
  always_comb begin
    shifted = {rem, quotient[DIV_W-1]};
    diff = shifted - {1'b0, dvs};
  end
  always_ff @(posedge clk)
    if (rst) begin
      rem <= '0;
      quotient <= '0;
      dvs <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else if (start) begin
      rem <= '0;
      quotient <= dividend;
      dvs <= divisor;
      cnt <= 7'd64;
      done <= 1'b0;
    end else begin
      if (cnt != 7'd0) begin
        rem <= diff[DIV_W] ? shifted[DIV_W-1:0] : diff[DIV_W-1:0];
        quotient <= {quotient[DIV_W-2:0], ~diff[DIV_W]};
        cnt <= cnt - 7'd1;
      end
      done <= cnt == 7'd1;
    end
endmodule

// File: rtl/line_regression.sv
// line_regression: per-frame least-squares line fit (slope, intercept, centroid) of tracked pixels.
// Defining LINE_REGRESSION_COUNT_EN adds count_out, the pixel count of the last fitted frame.
module line_regression import line_regression_pkg::*; #(
  parameter int H_WIDTH = 11,
  parameter int V_WIDTH = 10,
  parameter int FRAC_BITS = FP_FRAC
) (
  input logic clk_in,
  input logic rst_in,
  line_regression_if.slave bus
`ifdef LINE_REGRESSION_COUNT_EN
  , output logic [N_W-1:0] count_out
`endif
);
  state_t state, state_nx;
  logic [6:0] cnt;
  logic last, accept, div_start, div_done, n0, den0;
  logic [N_W-1:0] n, n_nx, sn;
  logic [S_W-1:0] sx, sx_nx, sy, sy_nx, ssx, ssy;
  logic [SS_W-1:0] sxx, sxx_nx, sxy, sxy_nx, ssxx, ssxy;
  logic [PROD_W-1:0] p_nsxy, p_sxsy, p_nsxx, p_sxsx, num, den, num_mag, den_mag;
  logic [PROD_W+FRAC_BITS-1:0] num_sh;
  logic [DIV_W-1:0] sx64, sy64, n64, bnum, bnum_mag, dvd, dvs, q;
  logic [FP_W-1:0] m_q, b_q;
  logic [H_WIDTH-1:0] xq;
  logic [V_WIDTH-1:0] yq;
  assign accept = bus.tabulate_in && state == IDLE;
  assign last = cnt == (state == PREP ? 7'd1 : 7'(DIV_LAT - 1));
  assign n0 = sn == '0;
  assign den0 = den == '0;
  assign bus.busy_out = state != IDLE;
  always_comb begin
    n_nx = n + N_W'(bus.valid_in);
    sx_nx = sx + (bus.valid_in ? S_W'(bus.x_in) : '0);
    sy_nx = sy + (bus.valid_in ? S_W'(bus.y_in) : '0);
    sxx_nx = sxx + (bus.valid_in ? SS_W'(bus.x_in) * SS_W'(bus.x_in) : '0);
    sxy_nx = sxy + (bus.valid_in ? SS_W'(bus.x_in) * SS_W'(bus.y_in) : '0);
  end
  always_comb begin
    state_nx = state;
    if (accept) state_nx = PREP;
    else if (state == DONE) state_nx = IDLE;
    else if (state != IDLE && last) state_nx = state_t'(state + 3'd1);
  end
  // Divisions run on magnitudes; oversized dividends clamp, which only matters where m saturates anyway
  always_comb begin
    n64 = DIV_W'(sn);
    sx64 = DIV_W'(ssx);
    sy64 = DIV_W'(ssy);
    num_mag = num[PROD_W-1] ? -num : num;
    den_mag = den[PROD_W-1] ? -den : den;
    num_sh = {num_mag, {FRAC_BITS{1'b0}}};
    bnum = (sy64 << FRAC_BITS) - {{(DIV_W-FP_W){m_q[FP_W-1]}}, m_q} * sx64;
    bnum_mag = bnum[DIV_W-1] ? -bnum : bnum;
    dvd = state == DIV_X ? sx64 : state == DIV_Y ? sy64 : state == DIV_B ? bnum_mag
        : |num_sh[PROD_W+FRAC_BITS-1:DIV_W] ? '1 : num_sh[DIV_W-1:0];
    dvs = state != DIV_M ? n64 : |den_mag[PROD_W-1:DIV_W] ? '1 : den_mag[DIV_W-1:0];
    div_start = state inside {DIV_X, DIV_Y, DIV_M, DIV_B} && cnt == 7'd0;
  end
  seq_divider u_div (
    .clk(clk_in), .rst(rst_in), .start(div_start),
    .dividend(dvd), .divisor(dvs), .quotient(q), .done(div_done)
  );
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state <= IDLE;
      cnt <= '0;
      {n, sx, sy, sxx, sxy} <= '0;
      {sn, ssx, ssy, ssxx, ssxy} <= '0;
      bus.m_out <= '0;
      bus.b_out <= '0;
      bus.x_com_out <= '0;
      bus.y_com_out <= '0;
      bus.valid_out <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state_nx != state ? 7'd0 : cnt + 7'd1;
      n <= accept ? '0 : n_nx;
      sx <= accept ? '0 : sx_nx;
      sy <= accept ? '0 : sy_nx;
      sxx <= accept ? '0 : sxx_nx;
      sxy <= accept ? '0 : sxy_nx;
      if (accept) {sn, ssx, ssy, ssxx, ssxy} <= {n_nx, sx_nx, sy_nx, sxx_nx, sxy_nx};
      if (state == PREP && cnt == 7'd0) begin
        p_nsxy <= PROD_W'(sn) * PROD_W'(ssxy);
        p_sxsy <= PROD_W'(ssx) * PROD_W'(ssy);
        p_nsxx <= PROD_W'(sn) * PROD_W'(ssxx);
        p_sxsx <= PROD_W'(ssx) * PROD_W'(ssx);
      end
      if (state == PREP && cnt == 7'd1) begin
        num <= p_nsxy - p_sxsy;
        den <= p_nsxx - p_sxsx;
      end
      if (div_done && state == DIV_X) xq <= q[H_WIDTH-1:0];
      if (div_done && state == DIV_Y) yq <= q[V_WIDTH-1:0];
      if (div_done && state == DIV_M) m_q <= sat_fp(q, num[PROD_W-1]);
      if (div_done && state == DIV_B) b_q <= sat_fp(q, bnum[DIV_W-1]);
      bus.valid_out <= state == DONE;
      if (state == DONE) begin
        bus.m_out <= n0 ? '0 : den0 ? M_MAX : m_q;
        bus.b_out <= n0 || den0 ? '0 : b_q;
        bus.x_com_out <= n0 ? '0 : xq;
        bus.y_com_out <= n0 ? '0 : yq;
      end
    end
`ifdef LINE_REGRESSION_COUNT_EN
  always_ff @(posedge clk_in)
    count_out <= rst_in ? '0 : state == DONE ? sn : count_out;
`endif
endmodule

// File: tb/tb_line_regression.sv
// tb_line_regression: directed frames with hand-computed fits for line_regression.
module tb_line_regression;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int lat, pulses;
  logic b1, b267;
  line_regression_if #(.H_WIDTH(11), .V_WIDTH(10)) bus ();
`ifdef LINE_REGRESSION_COUNT_EN
  logic [19:0] count;
`endif
  line_regression #(.H_WIDTH(11), .V_WIDTH(10), .FRAC_BITS(8)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
`ifdef LINE_REGRESSION_COUNT_EN
    , .count_out(count)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic check_res(input string tag, input logic [63:0] m, b, xc, yc);
    check({tag, ".m"}, bus.m_out, m);
    check({tag, ".b"}, bus.b_out, b);
    check({tag, ".xcom"}, bus.x_com_out, xc);
    check({tag, ".ycom"}, bus.y_com_out, yc);
  endtask
  task automatic feed(input int x0, y0, dx, dy, cnt);
    for (int i = 0; i < cnt; i++) begin
      bus.x_in = 11'(x0 + dx * i);
      bus.y_in = 10'(y0 + dy * i);
      bus.valid_in = 1'b1;
      tick;
    end
    bus.valid_in = 1'b0;
  endtask
  task automatic run_fit(output int l, output logic busy1, busy267);
    bus.tabulate_in = 1'b1;
    tick;
    bus.tabulate_in = 1'b0;
    l = 1;
    busy1 = bus.busy_out;
    busy267 = 1'b0;
    while (!bus.valid_out && l < 400) begin
      tick;
      l++;
      if (l == 267) busy267 = bus.busy_out;
    end
  endtask
  task automatic expect_fit(input string tag, input logic [63:0] m, b, xc, yc);
    run_fit(lat, b1, b267);
    check({tag, ".latency"}, lat, 268);
    check({tag, ".busy_first"}, b1, 1);
    check({tag, ".busy_done"}, b267, 1);
    check({tag, ".busy_at_valid"}, bus.busy_out, 0);
    check_res(tag, m, b, xc, yc);
    tick;
    check({tag, ".valid_pulse"}, bus.valid_out, 0);
    check({tag, ".m_held"}, bus.m_out, m);
  endtask
  initial begin
    bus.x_in = '0;
    bus.y_in = '0;
    bus.valid_in = 1'b0;
    bus.tabulate_in = 1'b0;
    repeat (3) tick;
    check_res("reset", 0, 0, 0, 0);
    check("reset.valid", bus.valid_out, 0);
    check("reset.busy", bus.busy_out, 0);
    rst = 1'b0;
    tick;
    feed(0, 0, 1, 1, 100);
    expect_fit("diag", 64'h100, 0, 49, 49);
`ifdef LINE_REGRESSION_COUNT_EN
    check("diag.count", count, 100);
`endif
    feed(100, 50, 1, 0, 100);
    expect_fit("flat", 0, 64'h3200, 149, 50);
    feed(300, 0, 0, 1, 100);
    expect_fit("vertical", 64'h0FFFFFF, 0, 300, 49);
    feed(0, 100, 1, -1, 100);
    expect_fit("neg", 64'h1FFFF00, 64'h6400, 49, 50);
    feed(0, 0, 1, 1, 100);
    bus.tabulate_in = 1'b1;
    tick;
    bus.tabulate_in = 1'b0;
    repeat (99) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort.busy", bus.busy_out, 0);
    check_res("abort", 0, 0, 0, 0);
    pulses = 0;
    repeat (300) begin
      tick;
      if (bus.valid_out) pulses++;
    end
    check("abort.no_valid", pulses, 0);
    feed(0, 0, 1, 1, 100);
    expect_fit("diag2", 64'h100, 0, 49, 49);
    expect_fit("empty", 0, 0, 0, 0);
    feed(0, 0, 1, 1, 100);
    bus.tabulate_in = 1'b1;
    tick;
    bus.tabulate_in = 1'b0;
    lat = 1;
    while (!bus.valid_out && lat < 400) begin
      bus.tabulate_in = lat == 50;
      bus.valid_in = lat >= 50 && lat < 150;
      bus.x_in = 11'(lat + 50);
      bus.y_in = 10'd50;
      tick;
      lat++;
    end
    bus.tabulate_in = 1'b0;
    bus.valid_in = 1'b0;
    check("retab.latency", lat, 268);
    check_res("retab", 64'h100, 0, 49, 49);
    tick;
    expect_fit("retab_next", 0, 64'h3200, 149, 50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
